// File: rtl/frame_stream_packer_if.sv
// frame_stream_packer_if: 64-bit valid/ready output stream with last.
interface frame_stream_packer_if;
  logic [63:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;

  modport master (
    output m_data,
    output m_valid,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    input  m_last,
    output m_ready
  );
endinterface

// File: rtl/frame_stream_packer.sv
// frame_stream_packer: sync word, header and RAM payload words out on a
// valid/ready stream with last; reads are credit-gated so no word is lost.
module frame_stream_packer #(
  parameter int          ADDR_W     = 9,
  parameter int          RAM_LAT    = 1,
  parameter logic [63:0] SYNC_WORD  = 64'hA5A5123401020304,
  parameter logic [15:0] FRAME_TYPE = 16'h0002,
  parameter logic [15:0] LEN_OFFS   = 16'd4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 frame_en,
  input  logic [15:0]          frame_word_length,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [15:0]          dst_addr,
  input  logic [15:0]          src_addr,
  output logic                 ram_rd,
  output logic [ADDR_W-1:0]    ram_addr,
  input  logic [63:0]          ram_dout,
  frame_stream_packer_if.master m,
  output logic                 busy,
  output logic                 err_short,
  output logic                 err_overrun,
  output logic                 abort
);

  localparam logic [2:0] DEPTH = 3'(RAM_LAT + 2);
  localparam logic [1:0] PMAX  = 2'(RAM_LAT + 1);

  typedef enum logic [2:0] {
    IDLE, HDR0, HDR1, PAYLOAD, DRAIN
  } state_t;

  state_t state, state_n;

  logic              fe_s1, fe_s2, rise;
  logic [14:0]       n_words;
  logic              n_ok, start, short_req, flush;
  logic [15:0]       len_q, dst_q, src_q;
  logic [ADDR_W-1:0] addr;
  logic [13:0]       left;

  logic [64:0]       mem [0:3];
  logic [1:0]        wp, rp, wp_n, rp_n;
  logic [2:0]        cnt, infl;
  logic [RAM_LAT-1:0] pv, pl;
  logic              arrive, arr_last;
  logic              head_vld, head_last;
  logic [63:0]       head_data;
  logic              pop, pop_fifo, bypass, push;
  logic [64:0]       push_word;

  assign rise      = fe_s1 & ~fe_s2;
  assign n_words   = {1'b0, frame_word_length[15:2]}
                   + {14'd0, |frame_word_length[1:0]};
  assign n_ok      = n_words >= 15'd3;
  assign start     = (state == IDLE) & rise & enable & n_ok;
  assign short_req = (state == IDLE) & rise & enable & ~n_ok;
  assign busy      = state != IDLE;
  assign flush     = busy & ~enable;

  assign arrive    = pv[RAM_LAT-1];
  assign arr_last  = pl[RAM_LAT-1];

  // An empty FIFO forwards returning RAM data straight to the stream.
  assign head_vld  = (cnt != 3'd0) | arrive;
  assign head_data = (cnt != 3'd0) ? mem[rp][63:0] : ram_dout;
  assign head_last = (cnt != 3'd0) ? mem[rp][64] : arr_last;

  assign m.m_valid = head_vld;
  assign m.m_data  = head_data;
  assign m.m_last  = head_last & head_vld;

  assign pop      = head_vld & m.m_ready;
  assign pop_fifo = pop & (cnt != 3'd0);
  assign bypass   = arrive & (cnt == 3'd0) & m.m_ready;

  assign wp_n = (wp == PMAX) ? 2'd0 : wp + 2'd1;
  assign rp_n = (rp == PMAX) ? 2'd0 : rp + 2'd1;

  assign ram_addr = addr;
  assign ram_rd   = (state == PAYLOAD) & enable
                  & (({1'b0, cnt} + {1'b0, infl}) < {1'b0, DEPTH});

  always_comb begin
    push      = 1'b0;
    push_word = '0;
    unique case (1'b1)
      state == HDR0: begin
        push      = 1'b1;
        push_word = {1'b0, SYNC_WORD};
      end
      state == HDR1: begin
        push      = 1'b1;
        push_word = {1'b0, FRAME_TYPE,
                     len_q - LEN_OFFS, dst_q, src_q};
      end
      arrive & ~bypass: begin
        push      = 1'b1;
        push_word = {arr_last, ram_dout};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = HDR0;
      HDR0:    state_n = HDR1;
      HDR1:    state_n = PAYLOAD;
      PAYLOAD: if (ram_rd && left == 14'd1)
                 state_n = DRAIN;
      DRAIN:   if (pop && head_last)
                 state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (flush) state_n = IDLE;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= push_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fe_s1       <= 1'b0;
      fe_s2       <= 1'b0;
      state       <= IDLE;
      err_short   <= 1'b0;
      err_overrun <= 1'b0;
      abort       <= 1'b0;
      len_q       <= '0;
      dst_q       <= '0;
      src_q       <= '0;
      addr        <= '0;
      left        <= '0;
      wp          <= '0;
      rp          <= '0;
      cnt         <= '0;
      infl        <= '0;
      pv          <= '0;
      pl          <= '0;
    end else begin
      fe_s1       <= frame_en;
      fe_s2       <= fe_s1;
      state       <= state_n;
      err_short   <= short_req;
      err_overrun <= busy & rise;
      abort       <= flush;
      if (start) begin
        len_q <= frame_word_length;
        dst_q <= dst_addr;
        src_q <= src_addr;
        addr  <= base_addr;
        left  <= 14'(n_words - 15'd2);
      end else if (ram_rd) begin
        addr <= addr + ADDR_W'(1);
        left <= left - 14'd1;
      end
      if (flush) begin
        wp   <= '0;
        rp   <= '0;
        cnt  <= '0;
        infl <= '0;
        pv   <= '0;
        pl   <= '0;
      end else begin
        if (push)     wp <= wp_n;
        if (pop_fifo) rp <= rp_n;
        cnt  <= cnt + {2'b0, push} - {2'b0, pop_fifo};
        infl <= infl + {2'b0, ram_rd} - {2'b0, arrive};
        pv[0] <= ram_rd;
        pl[0] <= ram_rd & (left == 14'd1);
        for (int i = 1; i < RAM_LAT; i++) begin
          pv[i] <= pv[i-1];
          pl[i] <= pl[i-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_stream_packer.sv
// tb_frame_stream_packer: directed frame vectors against RAM_LAT=1 and
// RAM_LAT=2 instances sharing stimulus and stream backpressure.
module tb_frame_stream_packer;

  localparam logic [63:0] SYNC = 64'hA5A5123401020304;

  typedef struct {
    logic [15:0] len;
    logic [8:0]  base;
    logic [15:0] dst;
    logic [15:0] src;
    bit          stall;
    bit          ovr;
    int          n;
    logic [63:0] hdr1;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, enable, frame_en, rdy, clr, stall_mode;
  logic [15:0] fwl, dst, src;
  logic [8:0]  base;
  int          cyc = 0;
  int          nvec = 0;
  int          nerr = 0;

  logic        vld[2], lst[2], rrd[2], bsy[2];
  logic        es[2], eo[2], ab[2];
  logic [63:0] dat[2], rdo[2], st1[2], st2[2];
  logic [8:0]  radr[2];

  logic [63:0] wbuf[2][64];
  int          nhs[2], nlast[2], last_idx[2], stab[2];
  int          first_v[2], first_hs[2], last_hs[2];
  int          nshort[2], novr[2], nab[2], rdout[2];
  logic        held[2], hl[2];
  logic [63:0] hd[2];
  logic [8:0]  alog[64];
  int          nrd;

  frame_stream_packer_if s0 ();
  frame_stream_packer_if s1 ();

  assign s0.m_ready = rdy;
  assign s1.m_ready = rdy;
  assign vld[0] = s0.m_valid;
  assign vld[1] = s1.m_valid;
  assign dat[0] = s0.m_data;
  assign dat[1] = s1.m_data;
  assign lst[0] = s0.m_last;
  assign lst[1] = s1.m_last;

  frame_stream_packer #(.RAM_LAT(1)) dut (
    .clk(clk), .rst(rst), .enable(enable), .frame_en(frame_en),
    .frame_word_length(fwl), .base_addr(base),
    .dst_addr(dst), .src_addr(src),
    .ram_rd(rrd[0]), .ram_addr(radr[0]), .ram_dout(rdo[0]),
    .m(s0), .busy(bsy[0]), .err_short(es[0]),
    .err_overrun(eo[0]), .abort(ab[0]));

  frame_stream_packer #(.RAM_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .enable(enable), .frame_en(frame_en),
    .frame_word_length(fwl), .base_addr(base),
    .dst_addr(dst), .src_addr(src),
    .ram_rd(rrd[1]), .ram_addr(radr[1]), .ram_dout(rdo[1]),
    .m(s1), .busy(bsy[1]), .err_short(es[1]),
    .err_overrun(eo[1]), .abort(ab[1]));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] rv(input logic [8:0] a);
    rv = {23'h5A5A5A, a, 23'h1F00F0, ~a};
  endfunction

  // RAM models: one and two cycle read latency
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      st1[k] <= rrd[k] ? rv(radr[k]) : 64'hBAD0_BAD0_BAD0_BAD0;
      st2[k] <= st1[k];
    end
  end
  assign rdo[0] = st1[0];
  assign rdo[1] = st2[1];

  initial begin
    int low;
    low = 0;
    rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (!stall_mode) begin
        rdy = 1'b1;
        low = 0;
      end else if (low > 0) begin
        rdy = 1'b0;
        low--;
      end else if ($urandom_range(0, 19) == 0) begin
        rdy = 1'b0;
        low = 10;
      end else begin
        rdy = ($urandom_range(0, 2) == 0);
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (clr) begin
        nhs[k]      <= 0;
        nlast[k]    <= 0;
        last_idx[k] <= -1;
        stab[k]     <= 0;
        first_v[k]  <= -1;
        first_hs[k] <= -1;
        last_hs[k]  <= -1;
        nshort[k]   <= 0;
        novr[k]     <= 0;
        nab[k]      <= 0;
        rdout[k]    <= 0;
        held[k]     <= 1'b0;
      end else if (!rst) begin
        if (vld[k] && rdy) begin
          if (nhs[k] < 64) wbuf[k][nhs[k][5:0]] <= dat[k];
          if (lst[k]) begin
            nlast[k]    <= nlast[k] + 1;
            last_idx[k] <= nhs[k];
          end
          if (nhs[k] == 0) first_hs[k] <= cyc;
          last_hs[k] <= cyc;
          nhs[k]     <= nhs[k] + 1;
        end
        if (held[k] && !(vld[k] && dat[k] == hd[k] && lst[k] == hl[k]))
          stab[k] <= stab[k] + 1;
        held[k] <= vld[k] && !rdy;
        hd[k]   <= dat[k];
        hl[k]   <= lst[k];
        if (vld[k] && first_v[k] < 0) first_v[k] <= cyc;
        if (es[k]) nshort[k] <= nshort[k] + 1;
        if (eo[k]) novr[k] <= novr[k] + 1;
        if (ab[k]) nab[k] <= nab[k] + 1;
        if (rrd[k] && !bsy[k]) rdout[k] <= rdout[k] + 1;
      end
    end
    if (clr) begin
      nrd <= 0;
    end else if (!rst && rrd[0]) begin
      if (nrd < 64) alog[nrd[5:0]] <= radr[0];
      nrd <= nrd + 1;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clear_mon();
    @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
  endtask

  task automatic run_frame(input vec_t v);
    int c0, to;
    clear_mon();
    stall_mode = v.stall;
    fwl  = v.len;
    base = v.base;
    dst  = v.dst;
    src  = v.src;
    frame_en = 1'b1;
    c0 = cyc;
    repeat (3) @(posedge clk);
    #1 frame_en = 1'b0;
    if (v.ovr) begin
      repeat (2) @(posedge clk);
      #1 frame_en = 1'b1;
      repeat (3) @(posedge clk);
      #1 frame_en = 1'b0;
    end
    to = 0;
    while ((bsy[0] || bsy[1]) && to < 1000) begin
      @(posedge clk);
      to++;
    end
    chk("frame_timeout", 64'(to < 1000), 64'd1);
    #1 stall_mode = 1'b0;
    repeat (3) @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("word_count", 64'(nhs[k]), 64'(v.n));
      chk("hdr0", wbuf[k][0], SYNC);
      chk("hdr1", wbuf[k][1], v.hdr1);
      for (int i = 2; i < v.n; i++)
        chk("payload", wbuf[k][i], rv(9'(v.base + 9'(i - 2))));
      chk("last_count", 64'(nlast[k]), 64'd1);
      chk("last_index", 64'(last_idx[k]), 64'(v.n - 1));
      chk("stall_hold", 64'(stab[k]), 64'd0);
      chk("latency", 64'(first_v[k] - c0), 64'd3);
      chk("overrun", 64'(novr[k]), 64'(v.ovr));
      chk("short", 64'(nshort[k]), 64'd0);
      chk("rd_idle", 64'(rdout[k]), 64'd0);
    end
    chk("rd_count", 64'(nrd), 64'(v.n - 2));
    for (int i = 0; i < v.n - 2; i++)
      chk("rd_addr", 64'(alog[i]), 64'(9'(v.base + 9'(i))));
    if (!v.stall)
      chk("gap_free", 64'(last_hs[0] - first_hs[0]), 64'(v.n - 1));
  endtask

  vec_t tv[6];

  initial begin
    int to;
    rst = 1'b1;
    enable = 1'b1;
    frame_en = 1'b0;
    clr = 1'b0;
    stall_mode = 1'b0;
    fwl = '0;
    base = '0;
    dst = '0;
    src = '0;
    tv[0] = '{16'd40, 9'd0, 16'h1111, 16'h2222, 1'b0, 1'b0, 10,
              64'h0002_0024_1111_2222};
    tv[1] = '{16'd41, 9'd5, 16'hABCD, 16'h0123, 1'b0, 1'b1, 11,
              64'h0002_0025_ABCD_0123};
    tv[2] = '{16'd40, 9'd0, 16'h1111, 16'h2222, 1'b1, 1'b0, 10,
              64'h0002_0024_1111_2222};
    tv[3] = '{16'd12, 9'd20, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 3,
              64'h0002_0008_0000_FFFF};
    tv[4] = '{16'd24, 9'd510, 16'h5555, 16'h6666, 1'b0, 1'b0, 6,
              64'h0002_0014_5555_6666};
    tv[5] = '{16'd9, 9'd100, 16'h0042, 16'h0099, 1'b1, 1'b0, 3,
              64'h0002_0005_0042_0099};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs",
        64'({vld[0], lst[0], rrd[0], bsy[0], es[0], eo[0], ab[0],
             vld[1], lst[1], rrd[1], bsy[1], es[1], eo[1], ab[1]}),
        64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 6; i++) run_frame(tv[i]);

    // too short: 8 units is two words
    clear_mon();
    fwl = 16'd8;
    frame_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 frame_en = 1'b0;
    repeat (8) @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("short_pulse", 64'(nshort[k]), 64'd1);
      chk("short_no_valid", 64'(first_v[k]), 64'hFFFF_FFFF_FFFF_FFFF);
      chk("short_idle", 64'(bsy[k]), 64'd0);
    end

    // abort mid-payload
    clear_mon();
    fwl = 16'd40;
    base = 9'd0;
    frame_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 frame_en = 1'b0;
    to = 0;
    while (nhs[0] < 5 && to < 200) begin
      @(posedge clk);
      to++;
    end
    chk("abort_wait", 64'(to < 200), 64'd1);
    #1 enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("abort_valid", 64'(vld[k]), 64'd0);
      chk("abort_busy", 64'(bsy[k]), 64'd0);
    end
    repeat (3) @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("abort_pulse", 64'(nab[k]), 64'd1);
      chk("abort_no_last", 64'(nlast[k]), 64'd0);
    end
    #1 enable = 1'b1;
    repeat (3) @(posedge clk);
    run_frame(tv[0]);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
